// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control: operand mux selects, load-use
// bubbles, data-memory wait freezes and a stall-cycle counter.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LD_USE   = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_EX = 2'd1;
  localparam logic [1:0] SEL_WB = 2'd2;
  localparam logic [1:0] SEL_LD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } rec_t;

  rec_t ex_q, ex_d;
  rec_t wb_q, wb_d;
  rec_t id_rec;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_ld_rd;
  logic rs1_hit_ld;
  logic rs2_hit_ld;
  logic lu_c;
  logic wait_c;
  logic stall_c;
  logic bubble_c;

  function automatic logic [1:0] sel_for(
    input logic             en,
    input logic [REG_W-1:0] rs,
    input rec_t             ex,
    input rec_t             wb
  );
    logic hit_ex;
    logic hit_wb;
    hit_ex  = ex.v & ex.we & ~ex.ld & (ex.rd == rs);
    hit_wb  = wb.v & wb.we & (wb.rd == rs);
    sel_for = SEL_RF;
    if (en && (rs != '0)) begin
      priority case (1'b1)
        hit_ex:  sel_for = SEL_EX;
        hit_wb:  sel_for = wb.ld ? SEL_LD : SEL_WB;
        default: sel_for = SEL_RF;
      endcase
    end
  endfunction

  assign id_rec.v  = id_valid;
  assign id_rec.rd = id_rd;
  assign id_rec.we = id_we;
  assign id_rec.ld = id_load;

  assign ex_ld_rd = ex_q.v & ex_q.ld & ex_q.we &
                    (ex_q.rd != '0);

  assign rs1_hit_ld = id_rs1_en & (id_rs1 == ex_q.rd);
  assign rs2_hit_ld = id_rs2_en & (id_rs2 == ex_q.rd);

  assign lu_c = id_valid & ex_ld_rd &
                (rs1_hit_ld | rs2_hit_ld);

  // WB load without data: everything freezes, even a load-use
  assign wait_c = wb_q.v & wb_q.ld & ~dmem_ready;

  always_comb begin
    state_d  = ST_RUN;
    ex_d     = ex_q;
    wb_d     = wb_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    unique case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (wait_c) begin
          stall_c = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (lu_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          wb_d     = ex_q;
          ex_d     = '0;
          state_d  = ST_LD_USE;
        end else begin
          wb_d = ex_q;
          ex_d = id_valid ? id_rec : '0;
        end
      end
      ST_LD_USE: begin
        if (wait_c) begin
          stall_c = 1'b1;
          state_d = ST_MEM_WAIT;
        end else begin
          wb_d = ex_q;
          ex_d = id_valid ? id_rec : '0;
        end
      end
      default: begin
        ex_d = '0;
        wb_d = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fwd_sel_a = SEL_RF;
    fwd_sel_b = SEL_RF;
    if (rst && id_valid) begin
      fwd_sel_a = sel_for(id_rs1_en, id_rs1,
                          ex_q, wb_q);
      fwd_sel_b = sel_for(id_rs2_en, id_rs2,
                          ex_q, wb_q);
    end
  end

  assign stall        = rst & stall_c;
  assign bubble       = rst & bubble_c;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: pipeline-record model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_en = 1'b0;
  logic       id_rs2_en = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_we = 1'b0;
  logic       id_load = 1'b0;
  logic       dmem_ready = 1'b1;

  logic [1:0]  sel_a, sel_b, sel_a2, sel_b2;
  logic        stall, bubble, stall2, bubble2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .dmem_ready(dmem_ready),
    .fwd_sel_a(sel_a), .fwd_sel_b(sel_b),
    .stall(stall), .bubble(bubble),
    .stall_cycles(cnt)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .dmem_ready(dmem_ready),
    .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2),
    .stall(stall2), .bubble(bubble2),
    .stall_cycles(cnt2)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } rec_t;

  rec_t m_ex = '0;
  rec_t m_wb = '0;
  int   m_cnt = 0;
  int   m_cnt2 = 0;
  bit   started = 1'b0;

  task automatic chk(input string n, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic int m_sel(input logic en,
                               input logic [4:0] rs);
    if (!rst || !id_valid || !en || rs == 0) return 0;
    if (m_ex.v && m_ex.we && !m_ex.ld && m_ex.rd == rs)
      return 1;
    if (m_wb.v && m_wb.we && m_wb.rd == rs)
      return m_wb.ld ? 3 : 2;
    return 0;
  endfunction

  function automatic bit m_wait();
    return m_wb.v && m_wb.ld && !dmem_ready;
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = (id_rs1_en && id_rs1 == m_ex.rd) ||
          (id_rs2_en && id_rs2 == m_ex.rd);
    return id_valid && m_ex.v && m_ex.ld && m_ex.we &&
           m_ex.rd != 0 && hit;
  endfunction

  function automatic bit m_stall();
    return rst && (m_wait() || m_lu());
  endfunction

  function automatic bit m_bubble();
    return rst && m_lu() && !m_wait();
  endfunction

  always @(posedge clk) begin : model
    bit w, lu, s;
    rec_t nid;
    w  = m_wait();
    lu = m_lu();
    s  = m_stall();
    nid = {1'b1, id_rd, id_we, id_load};
    if (!rst) begin
      m_ex    <= '0;
      m_wb    <= '0;
      m_cnt   <= 0;
      m_cnt2  <= 0;
      started <= 1'b1;
    end else begin
      if (s) begin
        m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
      end
      if (!w) begin
        m_wb <= m_ex;
        m_ex <= (lu || !id_valid) ? '0 : nid;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sel_a", sel_a, m_sel(id_rs1_en, id_rs1));
      chk("sel_b", sel_b, m_sel(id_rs2_en, id_rs2));
      chk("stall", stall, m_stall());
      chk("bubble", bubble, m_bubble());
      chk("cnt", cnt, m_cnt);
      chk("sel_a2", sel_a2, m_sel(id_rs1_en, id_rs1));
      chk("stall2", stall2, m_stall());
      chk("cnt2", cnt2, m_cnt2);
    end
  end

  task automatic set_id(input logic v,
                        input logic [4:0] r1, input logic e1,
                        input logic [4:0] r2, input logic e2,
                        input logic [4:0] rd, input logic we,
                        input logic ld);
    id_valid = v;
    id_rs1 = r1; id_rs1_en = e1;
    id_rs2 = r2; id_rs2_en = e2;
    id_rd = rd; id_we = we; id_load = ld;
  endtask

  task automatic half();
    @(negedge clk); #1;
  endtask

  task automatic full();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    dmem_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    full();
    half();
    chk("rst_stall", stall, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_cnt", cnt, 0);
    full();
    rst = 1'b1;

    // ADD x5 then a reader of x5/x6
    set_id(1, 0, 0, 0, 0, 5, 1, 0); full();
    set_id(1, 5, 1, 6, 1, 8, 1, 0); half();
    chk("t1_sel_a", sel_a, 1);
    chk("t1_sel_b", sel_b, 0);
    chk("t1_stall", stall, 0);
    full();

    // LW x7 then a reader of x7
    set_id(1, 0, 0, 0, 0, 7, 1, 1); full();
    set_id(1, 1, 1, 7, 1, 10, 1, 0); half();
    chk("t2_stall", stall, 1);
    chk("t2_bubble", bubble, 1);
    full(); half();
    chk("t2_sel_b", sel_b, 3);
    chk("t2_stall_after", stall, 0);
    chk("t2_bubble_after", bubble, 0);
    chk("t2_cnt", cnt, 1);
    full();

    // ADD x3, ADDI x3, reader; then x0
    set_id(1, 0, 0, 0, 0, 3, 1, 0); full();
    set_id(1, 0, 0, 0, 0, 3, 1, 0); full();
    set_id(1, 3, 1, 3, 1, 0, 1, 0); half();
    chk("t3_sel_a", sel_a, 1);
    chk("t3_sel_b", sel_b, 1);
    full();
    set_id(1, 0, 1, 3, 1, 12, 0, 0); half();
    chk("t3_x0_sel_a", sel_a, 0);
    chk("t3_wb_sel_b", sel_b, 2);
    full();

    // LW x9 reaching WB with three wait cycles
    set_id(1, 0, 0, 0, 0, 9, 1, 1); full();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); full();
    set_id(1, 9, 1, 0, 0, 13, 1, 0);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("t4_stall", stall, 1);
      chk("t4_bubble", bubble, 0);
      chk("t4_sel_a", sel_a, 3);
      full();
    end
    dmem_ready = 1'b1;
    half();
    chk("t4_release_stall", stall, 0);
    chk("t4_release_sel_a", sel_a, 3);
    chk("t4_cnt", cnt, 4);
    full();

    // wait on LW x2 in WB while LW x4 in EX has a user
    set_id(1, 0, 0, 0, 0, 2, 1, 1); full();
    set_id(1, 0, 0, 0, 0, 4, 1, 1); full();
    set_id(1, 4, 1, 0, 0, 14, 1, 0);
    dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("t5_wait_stall", stall, 1);
      chk("t5_wait_bubble", bubble, 0);
      full();
    end
    dmem_ready = 1'b1;
    half();
    chk("t5_lu_stall", stall, 1);
    chk("t5_lu_bubble", bubble, 1);
    full(); half();
    chk("t5_stall", stall, 0);
    chk("t5_sel_a", sel_a, 3);
    chk("t5_cnt", cnt, 7);
    chk("t5_cnt2_sat", cnt2, 3);
    full();

    // reset while in LD_USE
    set_id(1, 0, 0, 0, 0, 6, 1, 1); full();
    set_id(1, 6, 1, 0, 0, 15, 1, 0); half();
    chk("t6_pre_bubble", bubble, 1);
    full();
    rst = 1'b0; half();
    chk("t6_in_rst_stall", stall, 0);
    chk("t6_in_rst_sel_a", sel_a, 0);
    full();
    rst = 1'b1; half();
    chk("t6_stall", stall, 0);
    chk("t6_bubble", bubble, 0);
    chk("t6_sel_a", sel_a, 0);
    chk("t6_cnt", cnt, 0);
    full();

    // reset while in MEM_WAIT
    set_id(1, 0, 0, 0, 0, 9, 1, 1); full();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); full();
    set_id(1, 9, 1, 0, 0, 1, 1, 0);
    dmem_ready = 1'b0; half();
    chk("t6w_stall", stall, 1);
    full();
    rst = 1'b0; half();
    chk("t6w_in_rst_stall", stall, 0);
    full();
    rst = 1'b1; half();
    chk("t6w_stall_after", stall, 0);
    chk("t6w_sel_a", sel_a, 0);
    chk("t6w_cnt", cnt, 0);
    full();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      set_id(1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      half();
      full();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
